// File: rtl/bidir_arb_pkg.sv
// bidir_arb_pkg: shared types for the bidirectional pin arbiter
package bidir_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, TURN = 2'd2} state_t;
  typedef logic owner_t;
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;
  function automatic logic [1:0] onehot(input owner_t o);
    return o ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/bidir_pin_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; pointer names the favoured requester
module rr_arb2
  import bidir_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     ptr,
  input  logic       take,
  output owner_t     winner,
  output logic       valid,
  output owner_t     ptr_nxt
);
  assign winner  = (req == 2'b11) ? ptr : req[1];
  assign valid   = |req;
  assign ptr_nxt = (take && valid) ? ~winner : ptr;
endmodule

// File: rtl/bidir_pin_arbiter.sv
// bidir_pin_arbiter: time-shares one tri-state bus between two requesters,
// sequencing output enable, data select and turnaround gaps.
module bidir_pin_arbiter
  import bidir_arb_pkg::*;
#(
  parameter int W           = 8,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [1:0]   wr,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  input  logic [W-1:0] bus_in,
  output logic [1:0]   gnt,
  output logic         bus_oe,
  output logic [W-1:0] bus_out,
  output logic [W-1:0] rdata,
  output logic [1:0]   rvalid,
  output logic         busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t         state;
  owner_t         owner, ptr, win, ptr_nxt;
  logic           dir, win_valid, rel;
  logic [HW-1:0]  hold;
  logic [3:0]     turn;
  logic [W-1:0]   wsel_win, wsel_own;
  rr_arb2 u_arb (
    .req    (req),
    .ptr    (ptr),
    .take   (state == IDLE),
    .winner (win),
    .valid  (win_valid),
    .ptr_nxt(ptr_nxt)
  );
  assign wsel_win = win ? wdata1 : wdata0;
  assign wsel_own = owner ? wdata1 : wdata0;
  // hold counts completed OWN cycles, so release lands after exactly MAX_HOLD
  assign rel = !req[owner] || (hold >= HW'(MAX_HOLD - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      ptr     <= 1'b0;
      dir     <= DIR_RD;
      hold    <= '0;
      turn    <= '0;
      gnt     <= 2'b00;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      rdata   <= '0;
      rvalid  <= 2'b00;
      busy    <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      rvalid <= 2'b00;
      case (state)
        IDLE: if (win_valid) begin
          state  <= OWN;
          owner  <= win;
          dir    <= wr[win];
          hold   <= '0;
          gnt    <= onehot(win);
          bus_oe <= wr[win];
          busy   <= 1'b1;
          if (wr[win] == DIR_WR) bus_out <= wsel_win;
        end
        OWN: begin
          if (dir == DIR_WR) bus_out <= wsel_own;
          else begin
            rdata  <= bus_in;
            rvalid <= onehot(owner);
          end
          if (rel) begin
            state  <= (TURN_CYCLES > 0) ? TURN : IDLE;
            gnt    <= 2'b00;
            bus_oe <= 1'b0;
            busy   <= (TURN_CYCLES > 0);
            turn   <= '0;
          end else hold <= hold + 1'b1;
        end
        TURN: if (turn == 4'(TURN_CYCLES - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else turn <= turn + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bidir_pin_arbiter.md
Name: bidir_pin_arbiter

Overview:
- Shares one tri-state (inout) bus between two requesters.
- Each ownership is either a drive (write) or a sample (read). The block sequences output-enable, the 2:1 data select onto the bus, and turnaround gaps so two drivers never overlap.
- Sits between the requester logic and the pad-level tri-state assign; the top level does pin = bus_oe ? bus_out : 'z and feeds the pin back as bus_in.

Parameters:
- W, 8, bus data width.
- TURN_CYCLES, 1, forced bus-idle cycles (bus_oe=0) after every release; legal 0..15.
- MAX_HOLD, 8, maximum consecutive OWN cycles per grant; legal 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2  per-requester bus request, level; must stay high until granted.
- wr  input  2  per-requester direction, 1=drive, 0=sample; sampled at grant, locked for the ownership.
- wdata0  input  W  requester 0 drive data.
- wdata1  input  W  requester 1 drive data.
- bus_in  input  W  pin value read back from the pad.
- gnt  output  2  one-hot grant, high for every OWN cycle of the owner.
- bus_oe  output  1  pad output enable.
- bus_out  output  W  pad drive data.
- rdata  output  W  registered sample of bus_in.
- rvalid  output  2  one-hot, marks which requester rdata belongs to.
- busy  output  1  high in OWN or TURN.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; gnt=0, bus_oe=0, bus_out=0, rdata=0, rvalid=0, busy=0; round-robin pointer favours requester 0. Reset mid-ownership takes effect on that edge: bus_oe=0 in the next cycle.
- All outputs are registered, with no combinational path from any input to any output.
- States:
  - IDLE: no grant, bus_oe=0.
  - OWN: one owner, dir locked.
  - TURN: bus_oe=0, counting turnaround cycles.
- IDLE arbitration:
  - If any req is high, pick the winner and go to OWN next cycle.
  - Latency: req sampled high in cycle n gives gnt in cycle n+1.
  - Both high: the winner is the requester not granted most recently (pointer), then the pointer flips to the other.
  - Single request: that requester wins regardless of pointer; the pointer then points to the other.
- Entering OWN:
  - Latch owner and dir=wr[owner]; clear hold counter.
  - If dir=1, load bus_out<=wdata[owner] so the first OWN cycle drives valid data.
- OWN, dir=1:
  - bus_oe=1.
  - Each cycle bus_out<=wdata[owner], so bus data lags wdata by one cycle.
- OWN, dir=0:
  - bus_oe=0, bus_out held.
  - Each cycle rdata<=bus_in and rvalid<=onehot(owner). rvalid is therefore high in the cycle after each OWN cycle, including the cycle after the last one.
- Release: OWN ends when req[owner] is sampled low, or when the hold counter reaches MAX_HOLD (forced, even if req is still high).
  - If TURN_CYCLES>0, next state is TURN, else IDLE.
  - gnt and bus_oe drop on the same edge.
- TURN:
  - Lasts exactly TURN_CYCLES cycles, then IDLE.
  - Requests are ignored during TURN; they are arbitrated in IDLE.
- Gap: minimum bus_oe=0 gap between any two ownerships is TURN_CYCLES+1 cycles (TURN plus one IDLE cycle).
- Forced release with both req high: the other requester wins in IDLE.
- Forced release with only the same requester requesting: it is re-granted after the gap.
- wr changes during OWN are ignored. req of a non-owner during OWN has no effect.
- Counters:
  - Hold counter is $clog2(MAX_HOLD+1) bits, saturating compare, no wrap.
  - Turn counter is 4 bits.
- Invariant: bus_oe=1 implies exactly one gnt bit is set and dir=1.

Decomposition:
- Package bidir_arb_pkg: state typedef (IDLE/OWN/TURN), DIR_RD=1'b0, DIR_WR=1'b1, owner index typedef.
- One sub-module, rr_arb2: two-way round-robin picker.
  - Inputs: req[1:0], ptr, take.
  - Outputs: winner index, valid, next ptr.
- Top level holds the FSM, counters and data registers.

Test Plan:
- After reset, req0=1, wr0=1, wdata0=8'hA5 held 3 cycles then req0=0 -> gnt=01 and bus_oe=1 for 3 cycles starting 1 cycle after req; bus_out=A5; then bus_oe=0 for TURN+IDLE=2 cycles.
- req1=1, wr1=0, bus_in=8'h3C for 2 OWN cycles -> gnt=10, bus_oe stays 0, rdata=3C with rvalid=10 on the 2 cycles following each OWN cycle.
- req0 and req1 both raised in the same IDLE cycle, both drive -> order 0,1,0,1 across successive grants; never bus_oe=1 with gnt=11; at least 2 bus_oe=0 cycles between grants.
- MAX_HOLD=8, req0 held high 20 cycles, req1=0 -> OWN exactly 8 cycles, 2-cycle gap, re-grant to 0; with req1 also high, req1 is granted after the first 8 cycles.
- rst asserted in the 3rd cycle of a drive ownership -> next cycle bus_oe=0, gnt=00, busy=0; with req1 and req0 both high after reset, requester 0 wins first.
- TURN_CYCLES=0 build, back-to-back drive/read handover -> exactly one bus_oe=0 IDLE cycle between ownerships.
